pwm_host_bridge: RTL and testbench

Byte-wide host interface that sits directly upstream of the 32-channel timed-PWM engine on the FPGA shield. It accepts framed byte transfers from the shield's microcontroller over an asynchronous 8-bit strobed bus. It assembles 32-bit words and sequences the engine's RAM port (Addr, DataIn, RAMWrite, AddrStrobe, DataStrobe, DataOut). It also owns the engine's Run and Terminate controls.

---
 rtl/pwm_host_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_pwm_host_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_host_bridge.sv
// Byte-wide host bridge for the 32-channel timed-PWM engine.
// Frames host bytes into engine RAM cycles plus Run/Terminate control.
`timescale 1ns/1ps
module pwm_host_bridge (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        HostCs,
  input  logic        HostStb,
  input  logic        HostRnW,
  input  logic [7:0]  HostD,
  output logic [7:0]  HostDOut,
  output logic        Busy,
  output logic [7:0]  Addr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut,
  output logic        RAMWrite,
  output logic        AddrStrobe,
  output logic        DataStrobe,
  output logic        Run,
  output logic [31:0] Terminate
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DATA,
    S_WSETUP, S_WSTROBE, S_WHOLD,
    S_RSETUP, S_RSTROBE, S_RCAP,
    S_RDATA, S_DISCARD
  } state_t;

  state_t      state;
  logic        cs_s1, cs_s2, cs_d;
  logic        stb_s1, stb_s2, stb_d;
  logic        stb_rise;
  logic [7:0]  byte_q;
  logic        rnw_q;
  logic [7:0]  cmd;
  logic [7:0]  addr_q;
  logic [23:0] wbuf;
  logic [31:0] rbuf;
  logic [1:0]  cnt;
  logic        armed;

  logic        cs_rise;
  logic        wr_acc;
  logic        rd_acc;
  logic [31:0] next_word;

  assign cs_rise   = cs_s2 & ~cs_d;
  assign wr_acc    = stb_rise & ~rnw_q;
  assign rd_acc    = stb_rise & rnw_q;
  assign next_word = {byte_q, wbuf};
  assign HostDOut  = rbuf[7:0];

  // Synchronize host controls and register one pulse per strobe edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cs_s1    <= 1'b0;
      cs_s2    <= 1'b0;
      cs_d     <= 1'b0;
      stb_s1   <= 1'b0;
      stb_s2   <= 1'b0;
      stb_d    <= 1'b0;
      stb_rise <= 1'b0;
      byte_q   <= 8'h00;
      rnw_q    <= 1'b0;
    end else begin
      cs_s1    <= HostCs;
      cs_s2    <= cs_s1;
      cs_d     <= cs_s2;
      stb_s1   <= HostStb;
      stb_s2   <= stb_s1;
      stb_d    <= stb_s2;
      stb_rise <= stb_s2 & ~stb_d;
      if (stb_s2 & ~stb_d) begin
        byte_q <= HostD;
        rnw_q  <= HostRnW;
      end
    end
  end

  // Frame decoder and engine bus sequencer with registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      cmd        <= 8'h00;
      addr_q     <= 8'h00;
      wbuf       <= 24'h0;
      rbuf       <= 32'h0;
      armed      <= 1'b0;
      Addr       <= 8'h00;
      DataIn     <= 32'h0;
      RAMWrite   <= 1'b0;
      AddrStrobe <= 1'b0;
      DataStrobe <= 1'b0;
      Busy       <= 1'b0;
      Run        <= 1'b0;
      Terminate  <= 32'h0;
    end else begin
      if (cs_rise)
        armed <= 1'b1;
      else if (!cs_s2)
        armed <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= 2'd0;
          if (cs_s2 && armed && wr_acc) begin
            armed <= 1'b0;
            cmd   <= byte_q;
            case (byte_q)
              8'h01, 8'h02: state <= S_ADDR;
              8'h10, 8'h20: state <= S_DATA;
              default:      state <= S_DISCARD;
            endcase
          end
        end
        S_ADDR: begin
          if (!cs_s2) begin
            state <= S_IDLE;
          end else if (wr_acc) begin
            addr_q <= byte_q;
            if (cmd == 8'h02) begin
              Addr  <= byte_q;
              Busy  <= 1'b1;
              state <= S_RSETUP;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (!cs_s2) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
          end else if (wr_acc) begin
            wbuf <= next_word[31:8];
            cnt  <= cnt + 2'd1;
            if (cmd == 8'h20) begin
              Run   <= byte_q[0];
              state <= S_IDLE;
            end else if (cnt == 2'd3) begin
              if (cmd == 8'h10) begin
                Terminate <= next_word;
                state     <= S_IDLE;
              end else begin
                DataIn   <= next_word;
                Addr     <= addr_q;
                RAMWrite <= 1'b1;
                Busy     <= 1'b1;
                state    <= S_WSETUP;
              end
            end
          end
        end
        S_WSETUP: begin
          DataStrobe <= 1'b1;
          state      <= S_WSTROBE;
        end
        S_WSTROBE: begin
          DataStrobe <= 1'b0;
          state      <= S_WHOLD;
        end
        S_WHOLD: begin
          RAMWrite <= 1'b0;
          Busy     <= 1'b0;
          state    <= S_IDLE;
        end
        S_RSETUP: begin
          AddrStrobe <= 1'b1;
          state      <= S_RSTROBE;
        end
        S_RSTROBE: begin
          AddrStrobe <= 1'b0;
          state      <= S_RCAP;
        end
        S_RCAP: begin
          rbuf  <= DataOut;
          Busy  <= 1'b0;
          cnt   <= 2'd0;
          state <= cs_s2 ? S_RDATA : S_IDLE;
        end
        S_RDATA: begin
          if (!cs_s2) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
          end else if (rd_acc) begin
            rbuf <= {8'h00, rbuf[31:8]};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= S_IDLE;
              cnt   <= 2'd0;
            end
          end
        end
        S_DISCARD: begin
          if (!cs_s2) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_host_bridge.sv
// Bench for pwm_host_bridge: random host frames against an engine
// memory model, with cycle-exact checks of the engine strobes.
`timescale 1ns/1ps
module tb_pwm_host_bridge;

  logic        Clk;
  logic        Rst;
  logic        HostCs;
  logic        HostStb;
  logic        HostRnW;
  logic [7:0]  HostD;
  logic [7:0]  HostDOut;
  logic        Busy;
  logic [7:0]  Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        RAMWrite;
  logic        AddrStrobe;
  logic        DataStrobe;
  logic        Run;
  logic [31:0] Terminate;

  pwm_host_bridge dut (
    .Clk(Clk), .Rst(Rst),
    .HostCs(HostCs), .HostStb(HostStb),
    .HostRnW(HostRnW), .HostD(HostD),
    .HostDOut(HostDOut), .Busy(Busy),
    .Addr(Addr), .DataIn(DataIn),
    .DataOut(DataOut), .RAMWrite(RAMWrite),
    .AddrStrobe(AddrStrobe), .DataStrobe(DataStrobe),
    .Run(Run), .Terminate(Terminate)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // engine RAM stub with a bench preload port
  logic [31:0] eng_mem [256];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  assign DataOut = eng_mem[Addr];
  always @(posedge Clk) begin
    if (pre_we)
      eng_mem[pre_a] <= pre_d;
    else if (DataStrobe && RAMWrite)
      eng_mem[Addr] <= DataIn;
  end

  // reference model state
  logic [31:0] ref_mem [256];
  logic        ref_run;
  logic [31:0] ref_term;

  int n_chk;
  int n_fail;

  // per-edge samples taken 1ns after each edge of a strobe
  logic        s_rw  [1:8];
  logic        s_ds  [1:8];
  logic        s_as  [1:8];
  logic        s_bz  [1:8];
  logic        s_run [1:8];
  logic [7:0]  s_hd  [1:8];
  logic [31:0] s_tm  [1:8];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one host strobe: high for hi edges, optional HostCs drop after
  // edge cs_k, outputs sampled after each of ns edges
  task automatic pulse(input logic rnw, input logic [7:0] d,
                       input int hi, input int cs_k, input int ns);
    @(negedge Clk);
    HostRnW = rnw;
    HostD   = d;
    HostStb = 1'b1;
    for (int k = 1; k <= ns; k++) begin
      @(posedge Clk);
      #1;
      s_rw[k]  = RAMWrite;
      s_ds[k]  = DataStrobe;
      s_as[k]  = AddrStrobe;
      s_bz[k]  = Busy;
      s_run[k] = Run;
      s_hd[k]  = HostDOut;
      s_tm[k]  = Terminate;
      if (k == hi || k == cs_k) begin
        @(negedge Clk);
        if (k == hi) HostStb = 1'b0;
        if (k == cs_k) HostCs = 1'b0;
      end
    end
  endtask

  task automatic wbyte(input logic [7:0] d);
    pulse(1'b0, d, 4, 0, 8);
  endtask

  task automatic cs_on();
    @(negedge Clk);
    HostCs = 1'b1;
    repeat (4) @(posedge Clk);
  endtask

  task automatic cs_off();
    @(negedge Clk);
    HostCs = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [31:0] d,
                          input int cs_k);
    cs_on();
    wbyte(8'h01);
    wbyte(a);
    wbyte(d[7:0]);
    wbyte(d[15:8]);
    wbyte(d[23:16]);
    pulse(1'b0, d[31:24], 4, cs_k, 8);
    check("wr_rw_n0", s_rw[3], 0);
    check("wr_rw_n1", s_rw[4], 1);
    check("wr_bz_n1", s_bz[4], 1);
    check("wr_ds_n1", s_ds[4], 0);
    check("wr_ds_n2", s_ds[5], 1);
    check("wr_ds_n3", s_ds[6], 0);
    check("wr_rw_n3", s_rw[6], 1);
    check("wr_rw_n4", s_rw[7], 0);
    check("wr_bz_n4", s_bz[7], 0);
    check("wr_addr", Addr, a);
    check("wr_data", DataIn, d);
    ref_mem[a] = d;
    cs_off();
  endtask

  task automatic rd_frame(input logic [7:0] a);
    logic [31:0] v;
    v = ref_mem[a];
    cs_on();
    wbyte(8'h02);
    wbyte(a);
    check("rd_bz_n1", s_bz[4], 1);
    check("rd_as_n1", s_as[4], 0);
    check("rd_as_n2", s_as[5], 1);
    check("rd_as_n3", s_as[6], 0);
    check("rd_bz_n3", s_bz[6], 1);
    check("rd_bz_n4", s_bz[7], 0);
    check("rd_hd_n4", s_hd[7], v[7:0]);
    for (int i = 0; i < 4; i++) begin
      check("rd_byte", HostDOut, v[8*i +: 8]);
      pulse(1'b1, 8'h00, 4, 0, 8);
      if (i < 3) check("rd_adv", s_hd[4], v[8*(i+1) +: 8]);
    end
    cs_off();
  endtask

  task automatic term_frame(input logic [31:0] v);
    cs_on();
    wbyte(8'h10);
    wbyte(v[7:0]);
    wbyte(v[15:8]);
    wbyte(v[23:16]);
    pulse(1'b0, v[31:24], 4, 0, 8);
    check("term_old", s_tm[3], ref_term);
    check("term_new", s_tm[4], v);
    ref_term = v;
    cs_off();
  endtask

  task automatic run_frame(input logic b);
    cs_on();
    wbyte(8'h20);
    pulse(1'b0, {7'h00, b}, 4, 0, 8);
    check("run_old", s_run[3], ref_run);
    check("run_new", s_run[4], b);
    ref_run = b;
    cs_off();
  endtask

  task automatic bad_frame(input logic [7:0] c);
    cs_on();
    wbyte(c);
    wbyte(8'h20);
    wbyte({7'h00, ~ref_run});
    wbyte(8'h10);
    check("bad_run", Run, ref_run);
    check("bad_term", Terminate, ref_term);
    cs_off();
  endtask

  task automatic abort_frame(input logic [7:0] a, input logic [31:0] d);
    int seen;
    cs_on();
    wbyte(8'h01);
    wbyte(a);
    wbyte(d[7:0]);
    wbyte(d[15:8]);
    cs_off();
    seen = 0;
    wbyte(d[23:16]);
    for (int k = 1; k <= 8; k++) seen += int'(s_rw[k]) + int'(s_ds[k]);
    wbyte(d[31:24]);
    for (int k = 1; k <= 8; k++) seen += int'(s_rw[k]) + int'(s_ds[k]);
    check("abort_nowr", seen, 0);
  endtask

  logic [7:0]  ra;
  logic [31:0] rd;
  logic [7:0]  rc;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    Rst     = 1'b1;
    HostCs  = 1'b0;
    HostStb = 1'b0;
    HostRnW = 1'b0;
    HostD   = 8'h00;
    pre_we  = 1'b0;
    pre_a   = 8'h00;
    pre_d   = 32'h0;
    ref_run  = 1'b0;
    ref_term = 32'h0;
    for (int i = 0; i < 256; i++) begin
      @(negedge Clk);
      pre_we = 1'b1;
      pre_a  = 8'(i);
      pre_d  = (i == 5) ? 32'hCAFEF00D : $urandom;
      ref_mem[i] = pre_d;
    end
    @(negedge Clk);
    pre_we = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_rw", RAMWrite, 0);
    check("rst_run", Run, 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(posedge Clk);

    wr_frame(8'h04, 32'h12345678, 0);
    rd_frame(8'h05);
    rd_frame(8'h04);
    term_frame(32'h00001000);
    run_frame(1'b1);

    // write whose frame select drops while the strobe is in flight
    wr_frame(8'h21, 32'hA5A55A5A, 3);
    rd_frame(8'h21);

    // host strobe landing inside the busy window is dropped
    cs_on();
    wbyte(8'h01);
    wbyte(8'h33);
    wbyte(8'h11);
    wbyte(8'h22);
    wbyte(8'h33);
    pulse(1'b0, 8'h44, 2, 0, 3);
    pulse(1'b0, 8'hAA, 3, 0, 8);
    check("bzd_rw_n1", s_rw[1], 1);
    check("bzd_ds_n2", s_ds[2], 1);
    check("bzd_ds_n3", s_ds[3], 0);
    check("bzd_rw_n4", s_rw[4], 0);
    check("bzd_bz_n4", s_bz[4], 0);
    check("bzd_data", DataIn, 32'h44332211);
    ref_mem[8'h33] = 32'h44332211;
    cs_off();
    rd_frame(8'h33);

    abort_frame(8'h40, 32'h01020304);
    rd_frame(8'h40);
    bad_frame(8'h7F);
    run_frame(1'b0);

    // reset in the middle of an engine write
    term_frame(32'hDEADBEEF);
    run_frame(1'b1);
    cs_on();
    wbyte(8'h01);
    wbyte(8'h50);
    wbyte(8'hEF);
    wbyte(8'hBE);
    wbyte(8'hAD);
    pulse(1'b0, 8'hDE, 4, 0, 5);
    check("mid_ds", s_ds[5], 1);
    @(negedge Clk);
    Rst    = 1'b1;
    HostCs = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_addr", Addr, 0);
    check("rst_din", DataIn, 0);
    check("rst_ram", RAMWrite, 0);
    check("rst_as", AddrStrobe, 0);
    check("rst_ds", DataStrobe, 0);
    check("rst_runv", Run, 0);
    check("rst_term", Terminate, 0);
    check("rst_hd", HostDOut, 0);
    check("rst_bz", Busy, 0);
    ref_mem[8'h50] = 32'hDEADBEEF;
    ref_run  = 1'b0;
    ref_term = 32'h0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    rd_frame(8'h50);

    for (int it = 0; it < 40; it++) begin
      ra = 8'($urandom_range(0, 255));
      rd = $urandom;
      case ($urandom_range(0, 5))
        0: wr_frame(ra, rd, 0);
        1: rd_frame(ra);
        2: term_frame(rd);
        3: run_frame(rd[0]);
        4: begin
          rc = rd[7:0];
          if (rc == 8'h01 || rc == 8'h02 || rc == 8'h10 || rc == 8'h20)
            rc = 8'h7F;
          bad_frame(rc);
        end
        default: abort_frame(ra, rd);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
